// File: rtl/vga_scanout.sv
// VGA timing generator with a 2x2 pixel-doubled framebuffer scanout.
// Counters step on pix_en; the address/data pipeline steps on the opposite phase.
module vga_scanout #(
  parameter int unsigned H_VIS = 640,
  parameter int unsigned H_FP  = 16,
  parameter int unsigned H_SW  = 96,
  parameter int unsigned H_BP  = 48,
  parameter int unsigned V_VIS = 480,
  parameter int unsigned V_FP  = 10,
  parameter int unsigned V_SW  = 2,
  parameter int unsigned V_BP  = 33,
  parameter int unsigned FB_W  = 320
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  output logic [16:0] fb_addr,
  input  logic [11:0] fb_data,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 12;
  localparam int unsigned CW    = 8;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_VIS + H_FP + H_SW - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_VIS + V_FP + V_SW - 1);
  localparam logic [AW-1:0] FB_W_C   = AW'(FB_W);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } ctl_t;

  logic          ph_q, ph_d;
  logic          pix_en, dp_en;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic          vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;
  logic          vga_clk_q, vga_clk_d;
  ctl_t          s1_q, s1_d;
  ctl_t          s2_q, s2_d;
  logic [DW-1:0] pix_q, pix_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] g_q, g_d;
  logic [CW-1:0] b_q, b_d;
  logic          visible, hs_act, vs_act;

  assign pix_en = ph_q;
  assign dp_en  = ~ph_q;

  // Raster counters, line base and tick-aligned status flags.
  always_comb begin
    ph_d          = ~ph_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_base_d   = line_base_q;
    vga_clk_d     = pix_en;
    frame_start_d = pix_en && (hcnt_q == '0) && (vcnt_q == '0);
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d      = '0;
          line_base_d = '0;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
          // Each framebuffer row covers two screen lines.
          if (vcnt_q[0] && (vcnt_q < V_VIS_C)) begin
            line_base_d = line_base_q + FB_W_C;
          end
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
    vblank_d = (vcnt_d >= V_VIS_C);
  end

  // Address, RAM capture and output stages; sync/blank ride alongside the data.
  always_comb begin
    visible   = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hs_act    = (hcnt_q >= HS_BEG_C) && (hcnt_q <= HS_END_C);
    vs_act    = (vcnt_q >= VS_BEG_C) && (vcnt_q <= VS_END_C);
    fb_addr_d = fb_addr_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    pix_d     = pix_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (dp_en) begin
      if (visible) begin
        fb_addr_d = line_base_q + AW'(hcnt_q >> 1);
      end
      s1_d.vis  = visible;
      s1_d.hs   = hs_act;
      s1_d.vs   = vs_act;
      s2_d      = s1_q;
      pix_d     = fb_data;
      hs_d      = ~s2_q.hs;
      vs_d      = ~s2_q.vs;
      blank_n_d = s2_q.vis;
      r_d       = s2_q.vis ? {pix_q[11:8], pix_q[11:8]} : '0;
      g_d       = s2_q.vis ? {pix_q[7:4], pix_q[7:4]}   : '0;
      b_d       = s2_q.vis ? {pix_q[3:0], pix_q[3:0]}   : '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ph_q          <= 1'b0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_base_q   <= '0;
      fb_addr_q     <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
      s1_q          <= '0;
      s2_q          <= '0;
      pix_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      ph_q          <= ph_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_base_q   <= line_base_d;
      fb_addr_q     <= fb_addr_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      pix_q         <= pix_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: a default-timing instance for address/data/sync checks and a
// shrunken-timing instance for whole-frame counts, blanking and mid-frame reset.
module tb_vga_scanout;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  // Default timing instance; RAM returns addr ^ 12'hA5C one cycle later.
  logic [16:0] a_addr;
  logic [11:0] a_data = 12'h000;
  logic        a_vclk, a_hs, a_vs, a_blank_n, a_sync_n, a_vblank, a_fs;
  logic [7:0]  a_r, a_g, a_b;
  logic [23:0] a_rgb;
  assign a_rgb = {a_r, a_g, a_b};
  always @(posedge clk) a_data <= a_addr[11:0] ^ 12'hA5C;

  vga_scanout u_dflt (
    .CLOCK_50(clk), .resetn(resetn), .fb_addr(a_addr), .fb_data(a_data),
    .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_blank_n),
    .VGA_SYNC_N(a_sync_n), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .vblank(a_vblank), .frame_start(a_fs)
  );

  // Small timing: 24 ticks/line (16 visible, HS 18..20), 12 lines (8 visible, VS 9..10).
  logic [16:0] b_addr;
  logic [11:0] b_data;
  logic        b_vclk, b_hs, b_vs, b_blank_n, b_sync_n, b_vblank, b_fs;
  logic [7:0]  b_r, b_g, b_b;
  logic [23:0] b_rgb;
  assign b_rgb  = {b_r, b_g, b_b};
  assign b_data = 12'hFFF;

  vga_scanout #(
    .H_VIS(16), .H_FP(2), .H_SW(3), .H_BP(3),
    .V_VIS(8), .V_FP(1), .V_SW(2), .V_BP(1), .FB_W(8)
  ) u_small (
    .CLOCK_50(clk), .resetn(resetn), .fb_addr(b_addr), .fb_data(b_data),
    .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank_n),
    .VGA_SYNC_N(b_sync_n), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .vblank(b_vblank), .frame_start(b_fs)
  );

  int n_vec = 0;
  int n_err = 0;
  int ec    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to clock edge e after reset release, sampling 1 time unit later.
  task automatic goto(input int e);
    if (ec < e) begin
      while (ec < e) begin
        @(posedge clk);
        ec++;
      end
      #1;
    end
  endtask

  int   hs_low, hs_fall, vs_low, vs_fall, blank_hi, rgb_bad;
  int   clk_rise, edge_bad, vbl_hi, fs_hi;
  logic hs_p, vs_p, clk_p;
  logic [23:0] rgb_p;

  initial begin
    // ---------------- reset values ----------------
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vclk",    32'(a_vclk), 32'd0);
    chk("rst_hs",      32'(a_hs), 32'd1);
    chk("rst_vs",      32'(a_vs), 32'd1);
    chk("rst_blank_n", 32'(a_blank_n), 32'd0);
    chk("rst_rgb",     32'(a_rgb), 32'd0);
    chk("rst_vblank",  32'(a_vblank), 32'd0);
    chk("rst_fs",      32'(a_fs), 32'd0);
    chk("rst_addr",    32'(a_addr), 32'd0);
    chk("sync_n",      32'(a_sync_n), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ec = 0;

    // ---------------- default timing: first ticks, address, data path ----------------
    goto(1);    chk("fs_e1", 32'(a_fs), 32'd0);      chk("vclk_e1", 32'(a_vclk), 32'd0);
    goto(2);    chk("fs_e2", 32'(a_fs), 32'd1);      chk("vclk_e2", 32'(a_vclk), 32'd1);
                chk("fs_small_e2", 32'(b_fs), 32'd1);
    goto(3);    chk("fs_e3", 32'(a_fs), 32'd0);      chk("addr_h1v0", 32'(a_addr), 32'd0);
    goto(4);    chk("rgb_pre", 32'(a_rgb), 32'd0);   chk("blank_pre", 32'(a_blank_n), 32'd0);
    goto(5);    chk("addr_h2v0", 32'(a_addr), 32'd1);
                chk("rgb_h0", 32'(a_rgb), 32'hAA55CC); chk("blank_h0", 32'(a_blank_n), 32'd1);
    goto(6);    chk("rgb_h0_hold", 32'(a_rgb), 32'hAA55CC);
    goto(7);    chk("rgb_h1", 32'(a_rgb), 32'hAA55CC);
    goto(9);    chk("rgb_h2", 32'(a_rgb), 32'hAA55DD);
    goto(1279); chk("addr_h639v0", 32'(a_addr), 32'd319);
    goto(1281); chk("addr_hold_h640", 32'(a_addr), 32'd319);
    goto(1283); chk("blank_h639", 32'(a_blank_n), 32'd1); chk("rgb_h639", 32'(a_rgb), 32'hBB6633);
    goto(1285); chk("blank_h640", 32'(a_blank_n), 32'd0); chk("rgb_h640", 32'(a_rgb), 32'd0);
    goto(1316); chk("hs_h655", 32'(a_hs), 32'd1);
    goto(1317); chk("hs_h656", 32'(a_hs), 32'd0);
    goto(1507); chk("hs_h751", 32'(a_hs), 32'd0);
    goto(1509); chk("hs_h752", 32'(a_hs), 32'd1);
    goto(1601); chk("addr_h0v1", 32'(a_addr), 32'd0);
    goto(3201); chk("addr_h0v2", 32'(a_addr), 32'd320);

    // ---------------- small timing: fresh start ----------------
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    ec = 0;
    goto(2);   chk("s_fs_e2", 32'(b_fs), 32'd1);
    goto(97);  chk("s_addr_h0v2", 32'(b_addr), 32'd8);
    goto(367); chk("s_addr_last", 32'(b_addr), 32'd31);
    goto(369); chk("s_addr_hold_h", 32'(b_addr), 32'd31);
    goto(383); chk("s_vblank_v7", 32'(b_vblank), 32'd0);
    goto(384); chk("s_vblank_v8", 32'(b_vblank), 32'd1);
    goto(385); chk("s_addr_hold_v", 32'(b_addr), 32'd31);
    goto(575); chk("s_vblank_v11", 32'(b_vblank), 32'd1);
    goto(576); chk("s_vblank_wrap", 32'(b_vblank), 32'd0);
    goto(577); chk("s_fs_e577", 32'(b_fs), 32'd0); chk("s_addr_wrap", 32'(b_addr), 32'd0);
    goto(578); chk("s_fs_frame", 32'(b_fs), 32'd1);

    // One full frame of outputs (positions 288..575, two samples each).
    hs_low = 0; hs_fall = 0; vs_low = 0; vs_fall = 0; blank_hi = 0; rgb_bad = 0;
    clk_rise = 0; edge_bad = 0; vbl_hi = 0; fs_hi = 0;
    goto(580);
    hs_p = b_hs; vs_p = b_vs; clk_p = b_vclk; rgb_p = b_rgb;
    for (int e = 581; e < 1157; e++) begin
      goto(e);
      if (!b_hs) hs_low++;
      if (hs_p && !b_hs) hs_fall++;
      if (!b_vs) vs_low++;
      if (vs_p && !b_vs) vs_fall++;
      if (b_blank_n) blank_hi++;
      if (b_rgb !== (b_blank_n ? 24'hFFFFFF : 24'h000000)) rgb_bad++;
      if (b_vclk && !clk_p) clk_rise++;
      if ((b_rgb !== rgb_p) && !(clk_p && !b_vclk)) edge_bad++;
      if (b_vblank) vbl_hi++;
      if (b_fs) fs_hi++;
      hs_p = b_hs; vs_p = b_vs; clk_p = b_vclk; rgb_p = b_rgb;
    end
    chk("frame_hs_low_cycles", hs_low, 72);
    chk("frame_hs_pulses", hs_fall, 12);
    chk("frame_vs_low_cycles", vs_low, 96);
    chk("frame_vs_pulses", vs_fall, 1);
    chk("frame_blank_hi", blank_hi, 256);
    chk("frame_rgb_vs_blank", rgb_bad, 0);
    chk("frame_vclk_rises", clk_rise, 288);
    chk("frame_rgb_on_vclk_fall", edge_bad, 0);
    chk("frame_vblank_cycles", vbl_hi, 192);
    chk("frame_fs_pulses", fs_hi, 1);

    // ---------------- reset mid-frame at (h=10, v=5) ----------------
    goto(1412);
    chk("pre_rst_blank", 32'(b_blank_n), 32'd1);
    chk("pre_rst_rgb", 32'(b_rgb), 32'hFFFFFF);
    chk("pre_rst_addr", 32'(b_addr), 32'd20);
    resetn = 1'b0;
    #1;
    chk("mid_rst_hs", 32'(b_hs), 32'd1);
    chk("mid_rst_vs", 32'(b_vs), 32'd1);
    chk("mid_rst_blank", 32'(b_blank_n), 32'd0);
    chk("mid_rst_rgb", 32'(b_rgb), 32'd0);
    chk("mid_rst_vclk", 32'(b_vclk), 32'd0);
    chk("mid_rst_addr", 32'(b_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_rst_blank", 32'(b_blank_n), 32'd0);
    chk("held_rst_fs", 32'(b_fs), 32'd0);
    chk("held_rst_vblank", 32'(b_vblank), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ec = 0;
    goto(1); chk("post_rst_fs_e1", 32'(b_fs), 32'd0);
    goto(2); chk("post_rst_fs_e2", 32'(b_fs), 32'd1); chk("post_rst_vclk", 32'(b_vclk), 32'd1);
    goto(5); chk("post_rst_addr_h2", 32'(b_addr), 32'd1);
             chk("post_rst_blank_h0", 32'(b_blank_n), 32'd1);
             chk("post_rst_rgb_h0", 32'(b_rgb), 32'hFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
